// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared types and token encodings for the event FIFO.
// The event layout matches the default configuration (8-bit timestamp, 10 processors).
package tt_um_jleugeri_ttt_pkg;

    localparam logic [1:0] START = 2'b10;
    localparam logic [1:0] STOP  = 2'b01;

    localparam int DEFAULT_TIMESTAMP_BITS = 8;
    localparam int DEFAULT_PID_BITS       = 4;

    typedef struct packed {
        logic [DEFAULT_TIMESTAMP_BITS-1:0] timestamp;
        logic [DEFAULT_PID_BITS-1:0]       processor_id;
        logic [1:0]                        startstop;
    } event_t;

    // Only a lone start or a lone stop flag is a real event; 00 and 11 are noise.
    function automatic logic is_token(input logic [1:0] startstop);
        logic result;
        case (startstop)
            START:   result = 1'b1;
            STOP:    result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_sync_fifo.sv
// Generic single-clock circular buffer; a push while full is ignored unless a pop frees a slot.
// Storage is not reset; only pointers and occupancy are.
module tt_um_jleugeri_ttt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH+1);

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_r;
    logic [PTR_BITS-1:0] rd_ptr_r;
    logic [CNT_BITS-1:0] count_r;
    logic                do_push_s;
    logic                do_pop_s;

    // Qualify requests against occupancy; a pop on a full buffer makes room for a same-cycle push.
    always_comb begin
        empty     = (count_r == {CNT_BITS{1'b0}});
        full      = (count_r == CNT_BITS'(DEPTH));
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        rdata     = mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop balance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_BITS{1'b0}};
            rd_ptr_r <= {PTR_BITS{1'b0}};
            count_r  <= {CNT_BITS{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_BITS'(1);
                2'b01:   count_r <= count_r - CNT_BITS'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tt_um_jleugeri_ttt_event_fifo.sv
// Timestamped event FIFO: filters start/stop tokens from the controller, stamps them with
// the current timestep and buffers them for the host, counting events lost to a full buffer.
module tt_um_jleugeri_ttt_event_fifo
    import tt_um_jleugeri_ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS = 10,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMESTAMP_BITS = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    input  logic [$clog2(NUM_PROCESSORS)-1:0] in_processor_id,
    input  logic [1:0]                        in_startstop,
    input  logic                              step_done,
    input  logic                              out_ready,
    input  logic                              clear_overflow,
    output logic                              out_valid,
    output logic [$clog2(NUM_PROCESSORS)-1:0] out_processor_id,
    output logic [1:0]                        out_startstop,
    output logic [TIMESTAMP_BITS-1:0]         out_timestamp,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_level,
    output logic                              overflow,
    output logic [7:0]                        dropped_count
);

    localparam int PID_BITS   = $clog2(NUM_PROCESSORS);
    localparam int ENTRY_BITS = TIMESTAMP_BITS + PID_BITS + 2;

    logic [TIMESTAMP_BITS-1:0] timestamp_r;
    logic                      overflow_r;
    logic [7:0]                dropped_r;
    logic                      push_req_s;
    logic                      pop_s;
    logic                      drop_s;
    logic                      empty_s;
    logic                      full_s;
    logic [ENTRY_BITS-1:0]     wr_entry_s;
    logic [ENTRY_BITS-1:0]     rd_entry_s;

    // Event filtering; the stamp uses the timestep value before any same-cycle increment.
    always_comb begin
        push_req_s       = in_valid && is_token(in_startstop);
        pop_s            = !empty_s && out_ready;
        drop_s           = push_req_s && full_s && !pop_s;
        wr_entry_s       = {timestamp_r, in_processor_id, in_startstop};
        out_valid        = !empty_s;
        out_timestamp    = rd_entry_s[ENTRY_BITS-1 -: TIMESTAMP_BITS];
        out_processor_id = rd_entry_s[PID_BITS+1 -: PID_BITS];
        out_startstop    = rd_entry_s[1:0];
        overflow         = overflow_r;
        dropped_count    = dropped_r;
    end

    tt_um_jleugeri_ttt_sync_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req_s),
        .wdata   (wr_entry_s),
        .pop     (pop_s),
        .rdata   (rd_entry_s),
        .empty   (empty_s),
        .full    (full_s),
        .count   (fill_level)
    );

    // Timestep counter, wrapping at its natural width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timestamp_r <= {TIMESTAMP_BITS{1'b0}};
        end else if (step_done) begin
            timestamp_r <= timestamp_r + TIMESTAMP_BITS'(1);
        end else begin
            timestamp_r <= timestamp_r;
        end
    end

    // Drop accounting; a drop coinciding with a clear is counted as the first after the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
            dropped_r  <= 8'd0;
        end else if (clear_overflow) begin
            overflow_r <= drop_s;
            dropped_r  <= drop_s ? 8'd1 : 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            dropped_r  <= (dropped_r == 8'hFF) ? 8'hFF : dropped_r + 8'd1;
        end else begin
            overflow_r <= overflow_r;
            dropped_r  <= dropped_r;
        end
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_fifo.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_tt_um_jleugeri_ttt_event_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_processor_id = 4'd0;
    logic [1:0] in_startstop = 2'b00;
    logic       step_done = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       out_valid;
    logic [3:0] out_processor_id;
    logic [1:0] out_startstop;
    logic [7:0] out_timestamp;
    logic [3:0] fill_level;
    logic       overflow;
    logic [7:0] dropped_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int ts;
        int pid;
        int ss;
    } ev_t;

    ev_t q[$];
    int  m_ts = 0;
    int  m_ovf = 0;
    int  m_drop = 0;

    tt_um_jleugeri_ttt_event_fifo dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_processor_id  (in_processor_id),
        .in_startstop     (in_startstop),
        .step_done        (step_done),
        .out_ready        (out_ready),
        .clear_overflow   (clear_overflow),
        .out_valid        (out_valid),
        .out_processor_id (out_processor_id),
        .out_startstop    (out_startstop),
        .out_timestamp    (out_timestamp),
        .fill_level       (fill_level),
        .overflow         (overflow),
        .dropped_count    (dropped_count)
    );

    always #5 clk = ~clk;

    // Behavioural model of one clock edge, from the pre-edge model state.
    function automatic void model_edge(input int v, input int pid, input int ss,
                                       input int st, input int rdy, input int clr);
        ev_t e;
        int  is_push;
        int  dropped;
        is_push = (v != 0) && (ss == 2 || ss == 1);
        dropped = 0;
        e.ts = m_ts;
        e.pid = pid;
        e.ss = ss;
        if (rdy != 0 && q.size() > 0) void'(q.pop_front());
        if (is_push != 0) begin
            if (q.size() < DEPTH) q.push_back(e);
            else dropped = 1;
        end
        if (clr != 0) begin
            m_ovf = 0;
            m_drop = 0;
        end
        if (dropped != 0) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
        end
        if (st != 0) m_ts = (m_ts + 1) % 256;
    endfunction

    task automatic tick(input int v, input int pid, input int ss,
                        input int st, input int rdy, input int clr);
        in_valid = v[0];
        in_processor_id = pid[3:0];
        in_startstop = ss[1:0];
        step_done = st[0];
        out_ready = rdy[0];
        clear_overflow = clr[0];
        @(posedge clk);
        model_edge(v, pid, ss, st, rdy, clr);
        #1;
        in_valid = 1'b0;
        step_done = 1'b0;
        out_ready = 1'b0;
        clear_overflow = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        q.delete();
        m_ts = 0;
        m_ovf = 0;
        m_drop = 0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 4'd0) begin
            failures++;
            $display("FAIL reset_empty: out_valid=%0b fill=%0d required 0/0", out_valid, fill_level);
        end
        checks++;
        if (overflow !== 1'b0 || dropped_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_ovf: overflow=%0b dropped=%0d required 0/0", overflow, dropped_count);
        end
    endtask

    task automatic test_first_push();
        tick(1, 3, 2, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_processor_id !== 4'd3 || out_startstop !== 2'b10 ||
            out_timestamp !== 8'd0 || fill_level !== 4'd1) begin
            failures++;
            $display("FAIL first_push: v=%0b pid=%0d ss=%b ts=%0d fill=%0d required 1/3/10/0/1",
                     out_valid, out_processor_id, out_startstop, out_timestamp, fill_level);
        end
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 4'd0) begin
            failures++;
            $display("FAIL pop_empty: v=%0b fill=%0d required 0/0", out_valid, fill_level);
        end
    endtask

    task automatic test_timestamp();
        tick(0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        tick(1, 7, 1, 1, 0, 0);
        tick(1, 1, 2, 0, 0, 0);
        checks++;
        if (out_timestamp !== 8'd2 || out_processor_id !== 4'd7 || out_startstop !== 2'b01) begin
            failures++;
            $display("FAIL ts_same_cycle: ts=%0d pid=%0d ss=%b required 2/7/01",
                     out_timestamp, out_processor_id, out_startstop);
        end
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if (out_timestamp !== 8'd3 || out_processor_id !== 4'd1 || fill_level !== 4'd1) begin
            failures++;
            $display("FAIL ts_next: ts=%0d pid=%0d fill=%0d required 3/1/1",
                     out_timestamp, out_processor_id, fill_level);
        end
        tick(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) tick(1, i + 1, (i % 2 == 0) ? 2 : 1, 0, 0, 0);
        checks++;
        if (fill_level !== 4'd8 || overflow !== 1'b1 || dropped_count !== 8'd1) begin
            failures++;
            $display("FAIL overflow: fill=%0d ovf=%0b dropped=%0d required 8/1/1",
                     fill_level, overflow, dropped_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_processor_id !== 4'(i + 1) ||
                out_startstop !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL overflow_order[%0d]: v=%0b pid=%0d ss=%b required pid %0d",
                         i, out_valid, out_processor_id, out_startstop, i + 1);
            end
            tick(0, 0, 0, 0, 1, 0);
        end
        checks++;
        if (fill_level !== 4'd0) begin
            failures++;
            $display("FAIL overflow_drain: fill=%0d required 0", fill_level);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) tick(1, i, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 9 - i, 1, 0, 1, 0);
            checks++;
            if (fill_level !== 4'd8 || dropped_count !== 8'(m_drop) ||
                out_processor_id !== 4'(q[0].pid)) begin
                failures++;
                $display("FAIL full_pushpop[%0d]: fill=%0d dropped=%0d pid=%0d required 8/%0d/%0d",
                         i, fill_level, dropped_count, out_processor_id, m_drop, q[0].pid);
            end
        end
    endtask

    task automatic test_clear();
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (overflow !== 1'b0 || dropped_count !== 8'd0) begin
            failures++;
            $display("FAIL clear: ovf=%0b dropped=%0d required 0/0", overflow, dropped_count);
        end
        tick(1, 5, 2, 0, 0, 1);
        checks++;
        if (overflow !== 1'b1 || dropped_count !== 8'd1 || fill_level !== 4'd8) begin
            failures++;
            $display("FAIL clear_with_drop: ovf=%0b dropped=%0d fill=%0d required 1/1/8",
                     overflow, dropped_count, fill_level);
        end
        for (int i = 0; i < 300; i++) tick(1, 2, 1, 0, 0, 0);
        checks++;
        if (dropped_count !== 8'd255) begin
            failures++;
            $display("FAIL saturate: dropped=%0d required 255", dropped_count);
        end
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 1, 1);
    endtask

    task automatic test_filter();
        tick(1, 4, 0, 0, 0, 0);
        tick(1, 4, 3, 0, 0, 0);
        checks++;
        if (fill_level !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL filter: fill=%0d v=%0b required 0/0", fill_level, out_valid);
        end
    endtask

    task automatic test_wrap_and_reset();
        apply_reset();
        for (int i = 0; i < 256; i++) tick(0, 0, 0, 1, 0, 0);
        tick(1, 6, 2, 0, 0, 0);
        checks++;
        if (out_timestamp !== 8'd0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ts_wrap: ts=%0d v=%0b required 0/1", out_timestamp, out_valid);
        end
        tick(1, 7, 1, 0, 0, 0);
        tick(1, 8, 2, 0, 0, 0);
        checks++;
        if (fill_level !== 4'd3) begin
            failures++;
            $display("FAIL pre_reset_fill: fill=%0d required 3", fill_level);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fill_level !== 4'd0) begin
            failures++;
            $display("FAIL async_reset: v=%0b fill=%0d required 0/0", out_valid, fill_level);
        end
        apply_reset();
    endtask

    task automatic test_random();
        int v, pid, ss, st, rdy, clr;
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 99) < 70) ? 1 : 0;
            pid = $urandom_range(0, 9);
            ss  = $urandom_range(0, 3);
            st  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            rdy = ($urandom_range(0, 99) < (((i / 200) % 2 == 0) ? 25 : 75)) ? 1 : 0;
            clr = ($urandom_range(0, 63) == 0) ? 1 : 0;
            tick(v, pid, ss, st, rdy, clr);
            checks++;
            if (fill_level !== 4'(q.size()) || out_valid !== (q.size() > 0) ||
                overflow !== m_ovf[0] || dropped_count !== 8'(m_drop)) begin
                failures++;
                $display("FAIL rand_status[%0d]: fill=%0d v=%0b ovf=%0b drop=%0d required %0d/%0b/%0d/%0d",
                         i, fill_level, out_valid, overflow, dropped_count,
                         q.size(), q.size() > 0, m_ovf, m_drop);
            end
            if (q.size() > 0) begin
                checks++;
                if (out_timestamp !== 8'(q[0].ts) || out_processor_id !== 4'(q[0].pid) ||
                    out_startstop !== 2'(q[0].ss)) begin
                    failures++;
                    $display("FAIL rand_head[%0d]: ts=%0d pid=%0d ss=%0d required %0d/%0d/%0d",
                             i, out_timestamp, out_processor_id, out_startstop,
                             q[0].ts, q[0].pid, q[0].ss);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_timestamp();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_filter();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
